// File: rtl/product_accumulator_if.sv
// Product-stream / result handshake bundle for product_accumulator.
// Master drives the product stream, start and ready; slave is the accumulator.
interface product_accumulator_if #(
  parameter int DATAWIDTH = 4,
  parameter int ACC_WIDTH = 16,
  parameter int MAX_LEN   = 16
);
  localparam int LEN_WIDTH = $clog2(MAX_LEN + 1);

  logic                   i_start;
  logic [LEN_WIDTH-1:0]   i_len;
  logic                   i_valid;
  logic [2*DATAWIDTH-1:0] i_product;
  logic                   i_ready;
  logic                   o_busy;
  logic                   o_valid;
  logic [ACC_WIDTH-1:0]   o_acc;
  logic                   o_overflow;
  logic                   o_drop;

  modport master (
    output i_start, i_len, i_valid, i_product, i_ready,
    input  o_busy, o_valid, o_acc, o_overflow, o_drop
  );

  modport slave (
    input  i_start, i_len, i_valid, i_product, i_ready,
    output o_busy, o_valid, o_acc, o_overflow, o_drop
  );
endinterface

// File: rtl/product_accumulator.sv
// Dot-product accumulator behind the array multiplier: sums i_len products, hands result off via valid/ready.
// Define PRODUCT_ACCUMULATOR_SATURATE_EN to clamp on overflow instead of wrapping.
module product_accumulator #(
  parameter int DATAWIDTH = 4,
  parameter int ACC_WIDTH = 16,
  parameter int MAX_LEN   = 16
) (
  input logic                  clk,
  input logic                  rst,
  product_accumulator_if.slave bus
);
  localparam int LEN_WIDTH = $clog2(MAX_LEN + 1);

  if (ACC_WIDTH < 2 * DATAWIDTH) begin : g_width_check
    $error("product_accumulator: ACC_WIDTH must be >= 2*DATAWIDTH");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 overflow;
  logic                 busy;
  logic                 valid;
  logic                 drop;

  logic [LEN_WIDTH-1:0] len_eff;
  logic [ACC_WIDTH:0]   sum;
  logic                 carry;
  logic [ACC_WIDTH-1:0] next_acc;
  logic                 take_start;

  // NOTE: every variable is given a value at the top of always_comb so no path can infer a latch.
  always_comb begin
    len_eff    = (bus.i_len > LEN_WIDTH'(MAX_LEN)) ? LEN_WIDTH'(MAX_LEN) : bus.i_len;
    sum        = {1'b0, acc} + {{(ACC_WIDTH + 1 - 2 * DATAWIDTH){1'b0}}, bus.i_product};
    carry      = sum[ACC_WIDTH];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    next_acc   = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    next_acc   = sum[ACC_WIDTH-1:0];
`endif
    take_start = bus.i_start && ((state == IDLE) || (state == DONE && bus.i_ready));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      drop      <= 1'b0;
    end else begin
      drop <= 1'b0;
      case (state)
        ACCUM: begin
          if (bus.i_valid) begin
            acc       <= next_acc;
            overflow  <= overflow | carry;
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              valid <= 1'b1;
            end
          end
        end
        default: begin
          // IDLE and DONE: the multiplier cannot be stalled, so a product here is lost.
          if (bus.i_valid) drop <= 1'b1;
          if (state == DONE && bus.i_ready) begin
            state <= IDLE;
            valid <= 1'b0;
          end
          if (take_start) begin
            acc      <= '0;
            overflow <= 1'b0;
            if (len_eff == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              valid <= 1'b1;
            end else begin
              state     <= ACCUM;
              busy      <= 1'b1;
              valid     <= 1'b0;
              remaining <= len_eff;
            end
          end
        end
      endcase
    end
  end

  assign bus.o_busy     = busy;
  assign bus.o_valid    = valid;
  assign bus.o_acc      = acc;
  assign bus.o_overflow = overflow;
  assign bus.o_drop     = drop;
endmodule

// File: tb/tb_product_accumulator.sv
// Directed-vector bench for product_accumulator (DATAWIDTH=4, ACC_WIDTH=10, MAX_LEN=8).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_product_accumulator;
  localparam int DW = 4;
  localparam int AW = 10;
  localparam int ML = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  product_accumulator_if #(.DATAWIDTH(DW), .ACC_WIDTH(AW), .MAX_LEN(ML)) bus ();

  product_accumulator #(.DATAWIDTH(DW), .ACC_WIDTH(AW), .MAX_LEN(ML)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start(input int len);
    bus.i_start = 1'b1;
    bus.i_len   = 4'(len);
  endtask

  task automatic product(input int p);
    bus.i_start   = 1'b0;
    bus.i_valid   = 1'b1;
    bus.i_product = 8'(p);
    tick();
  endtask

  initial begin
    bus.i_start   = 1'b0;
    bus.i_len     = '0;
    bus.i_valid   = 1'b0;
    bus.i_product = '0;
    bus.i_ready   = 1'b0;
    tick();
    tick();
    check("rst_busy", bus.o_busy, 0);
    check("rst_valid", bus.o_valid, 0);
    check("rst_acc", bus.o_acc, 0);
    check("rst_ovf", bus.o_overflow, 0);
    check("rst_drop", bus.o_drop, 0);
    rst = 1'b0;
    tick();

    // Basic sum 15 + 225 + 100 = 340
    start(3);
    tick();
    check("basic_busy", bus.o_busy, 1);
    product(15);
    product(225);
    check("basic_not_yet", bus.o_valid, 0);
    product(100);
    bus.i_valid = 1'b0;
    check("basic_valid", bus.o_valid, 1);
    check("basic_acc", bus.o_acc, 340);
    check("basic_ovf", bus.o_overflow, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("basic_hold_valid", bus.o_valid, 1);
      check("basic_hold_acc", bus.o_acc, 340);
    end
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    check("basic_release", bus.o_valid, 0);

    // Drop while IDLE: pulse one cycle, result register untouched
    bus.i_valid   = 1'b1;
    bus.i_product = 8'd50;
    tick();
    bus.i_valid = 1'b0;
    check("idle_drop", bus.o_drop, 1);
    check("idle_drop_acc", bus.o_acc, 340);
    tick();
    check("idle_drop_end", bus.o_drop, 0);

    // Gapped input 6 ... 9 = 15
    start(2);
    tick();
    product(6);
    bus.i_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("gap_busy", bus.o_busy, 1);
      check("gap_nodrop", bus.o_drop, 0);
    end
    product(9);
    bus.i_valid = 1'b0;
    check("gap_valid", bus.o_valid, 1);
    check("gap_acc", bus.o_acc, 15);
    check("gap_nodrop_end", bus.o_drop, 0);

    // Drop while DONE without handshake, plus an ignored start
    bus.i_valid   = 1'b1;
    bus.i_product = 8'd50;
    tick();
    bus.i_valid = 1'b0;
    check("done_drop", bus.o_drop, 1);
    check("done_drop_acc", bus.o_acc, 15);
    check("done_drop_valid", bus.o_valid, 1);
    start(3);
    tick();
    bus.i_start = 1'b0;
    check("done_drop_end", bus.o_drop, 0);
    check("done_start_ignored", bus.o_valid, 1);
    check("done_start_busy", bus.o_busy, 0);
    check("done_start_acc", bus.o_acc, 15);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;

    // Overflow: 5 x 225 = 1125 exceeds 1023
    start(5);
    tick();
    for (int i = 0; i < 5; i++) product(225);
    bus.i_valid = 1'b0;
    check("ovf_valid", bus.o_valid, 1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    check("ovf_acc", bus.o_acc, 1023);
`else
    check("ovf_acc", bus.o_acc, 101);
`endif
    check("ovf_flag", bus.o_overflow, 1);

    // Back-to-back: handshake and start len=1 together
    bus.i_ready = 1'b1;
    start(1);
    tick();
    bus.i_ready = 1'b0;
    check("b2b_busy", bus.o_busy, 1);
    check("b2b_valid_low", bus.o_valid, 0);
    product(7);
    bus.i_valid = 1'b0;
    check("b2b_valid", bus.o_valid, 1);
    check("b2b_acc", bus.o_acc, 7);
    check("b2b_ovf_cleared", bus.o_overflow, 0);
    bus.i_ready = 1'b1;
    start(0);
    tick();
    bus.i_start = 1'b0;
    bus.i_ready = 1'b0;
    check("len0_valid", bus.o_valid, 1);
    check("len0_acc", bus.o_acc, 0);
    check("len0_busy", bus.o_busy, 0);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
    check("len0_release", bus.o_valid, 0);

    // Length clamp: 15 -> 8 products of 1; a start inside ACCUM is ignored
    start(15);
    tick();
    for (int i = 0; i < 3; i++) product(1);
    bus.i_valid = 1'b0;
    start(1);
    tick();
    bus.i_start = 1'b0;
    check("accum_start_ignored", bus.o_busy, 1);
    check("accum_start_nodrop", bus.o_drop, 0);
    for (int i = 0; i < 4; i++) product(1);
    check("clamp_not_yet", bus.o_valid, 0);
    product(1);
    bus.i_valid = 1'b0;
    check("clamp_valid", bus.o_valid, 1);
    check("clamp_acc", bus.o_acc, 8);
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;

    // Reset mid-vector, then a fresh vector
    start(4);
    tick();
    product(10);
    product(10);
    bus.i_valid = 1'b0;
    check("midrst_partial", bus.o_acc, 20);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", bus.o_busy, 0);
    check("midrst_valid", bus.o_valid, 0);
    check("midrst_acc", bus.o_acc, 0);
    check("midrst_ovf", bus.o_overflow, 0);
    check("midrst_drop", bus.o_drop, 0);
    tick();
    check("midrst_no_result", bus.o_valid, 0);
    start(1);
    tick();
    product(3);
    bus.i_valid = 1'b0;
    check("after_rst_valid", bus.o_valid, 1);
    check("after_rst_acc", bus.o_acc, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
